sysarray_result_drain: RTL and testbench
========================================

# sysarray_result_drain

Read-side counterpart to the systolic array's operand feed. Snapshots the n×n accumulated result matrix from the PE grid when the array's step counter `flg` reaches the end-of-computation count. Streams the elements out one per cycle, in row-major order, over a valid/ready handshake. Sits between the `sysarray` PE grid and the result sink (host bus bridge or output FIFO).

## Interface
Parameters:
- `N`, 31: MSB index of one element; element width is N+1.
- `n`, 2: array dimension; the matrix has n×n elements.
- `DONE_FLG`, 3*n-1: value of `flg` at which the results are complete.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flg` in 7: array step counter, same signal that drives `sysarray`.
- `c_flat` in (N+1)*n*n: packed PE results. Element (r,c) is at bits [(r*n+c)*(N+1) +: N+1].
- `out_data` out N+1: current element.
- `out_row` out $clog2(n) (min 1): row index of `out_data`.
- `out_col` out $clog2(n) (min 1): column index of `out_data`.
- `out_valid` out 1: element presented.
- `out_ready` in 1: sink accepts.
- `out_last` out 1: current element is (n-1,n-1).
- `busy` out 1: a snapshot is held or being streamed.
- `ovf` out 1: sticky flag; a trigger arrived while busy.

## Operation
- States: IDLE, STREAM.
- **Trigger**: `flg == DONE_FLG` while the registered previous `flg` != DONE_FLG, i.e. a rising match.
  - A `flg` held at DONE_FLG does not retrigger.
  - Reset value of the previous-`flg` register is 0.
- **IDLE + trigger**:
  - Capture all of `c_flat` into the snapshot register on that edge.
  - Set the element index to (0,0) and go to STREAM.
- **STREAM**:
  - `out_valid`=1.
  - `out_data` = snapshot element at the current index, selected from the snapshot, never from live `c_flat`.
  - A transfer is `out_valid && out_ready` on a rising edge.
  - On a transfer, the index advances column-first: col+1; on col wrap to 0, row+1.
  - On a transfer with `out_last`=1, go to IDLE.
- **Backpressure**: while `out_valid && !out_ready`, `out_data`, `out_row`, `out_col` and `out_last` hold stable.
- **Trigger during STREAM**:
  - The trigger is ignored; the snapshot is not overwritten and streaming continues.
  - `ovf` is set and stays set until reset.
- **Trigger on the same edge as the final transfer**: the FSM goes to IDLE and the trigger is lost; `ovf` is set.
- Widths: no arithmetic on data; element values pass through bit-exact.
- **Reset** (asynchronous, any state):
  - state IDLE; index (0,0); snapshot 0.
  - `out_valid`=0, `out_last`=0, `busy`=0, `ovf`=0.
  - `out_data`=0, `out_row`=0, `out_col`=0.
  - Deasserting reset mid-operation resumes in IDLE; no partial stream continues.

## Timing
- Trigger edge E captures the snapshot. `out_valid` and `busy` rise after E; element (0,0) is visible in the cycle following E.
- With `out_ready` held at 1, the stream takes exactly n*n cycles.
  - `out_last` is high in cycle n*n after E.
  - `busy` falls after the edge that completes that transfer.
- Earliest re-trigger is accepted on the edge after `busy` falls.
- No combinational path from `out_ready` to `out_valid`. `out_valid`, `out_data`, indices, `busy` and `ovf` are registered or decoded from registered state only.

## Configuration
- `SYSARRAY_DRAIN_PARITY_EN` defined:
  - Adds output port `out_parity` (1 bit) = even parity (XOR reduce) of `out_data`.
  - It is registered alongside `out_data` and holds under backpressure. Reset value 0.
- Undefined: the port and its logic do not exist. All other behaviour is identical.

## Structure
- Shared package `sysarray_pkg`:
  - state enum {IDLE, STREAM}
  - index-width function (clog2 with minimum 1)
  - default N/n constants, shared with `sysarray` and its feed logic.
- One sub-module: `sysarray_elem_sel`, a combinational mux that selects element (row,col) from a packed n×n vector. It is reusable by the feed side.
- FSM, index counters, snapshot register and trigger edge detect live in the top module.

## Test plan
All scenarios use n=2 and N=31.
- **Basic drain**:
  - Stimulus: `c_flat` = {22,15,10,7} (element (0,0)=7), `flg` stepped 0..5, `out_ready`=1.
  - Response: one cycle after the flg=5 edge, the stream is 7,10,15,22 with (row,col) = (0,0),(0,1),(1,0),(1,1). `out_last` is asserted only on 22; `busy` drops after 4 transfers.
- **Backpressure**:
  - Stimulus: as above with `out_ready` low for 3 cycles while element 10 is presented.
  - Response: 10 and (0,1) hold stable for 3 cycles; the stream then completes 15,22 with no loss or duplication.
- **Snapshot isolation**:
  - Stimulus: change `c_flat` to all 0xFFFFFFFF one cycle after the trigger.
  - Response: output is still 7,10,15,22.
- **Hold and retrigger**:
  - Stimulus: hold `flg`=5 for 10 cycles. Then drop `flg` to 0 and return it to 5 during streaming.
  - Response: only one stream of 4 elements; `ovf`=1 after the second rise; the snapshot is unchanged.
- **Reset mid-stream**:
  - Stimulus: assert `rst_n`=0 asynchronously after 2 transfers.
  - Response: `out_valid`, `busy`, `ovf`, `out_data` = 0 immediately. After release, nothing is output until the next trigger, which streams from (0,0).
- **Parity** (with `SYSARRAY_DRAIN_PARITY_EN`):
  - Stimulus: basic drain.
  - Response: `out_parity` = 1,0,0,1 for 7,10,15,22.

Source files
------------

// File: rtl/sysarray_pkg.sv
// Shared definitions for the systolic array, its operand feed and its result drain.
package sysarray_pkg;

   // Default element MSB index and array dimension used across the array blocks
   localparam int SA_N   = 31;
   localparam int SA_DIM = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Width of a row/column index for an array of dimension v (never narrower than 1 bit)
   function automatic int idx_w(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/sysarray_elem_sel.sv
// Combinational selector of element (row,col) from a packed row-major n x n vector.
// Indices that fall outside the matrix (non power-of-two n) return zero.
module sysarray_elem_sel
   import sysarray_pkg::*;
#(
   parameter int N = SA_N,
   parameter int n = SA_DIM
) (
   input  logic [(N+1)*n*n-1:0] vec,
   input  logic [idx_w(n)-1:0]  row,
   input  logic [idx_w(n)-1:0]  col,
   output logic [N:0]           elem
);

   localparam int EW = N+1;

   int idx;

   // Flatten (row,col) to the row-major element number and slice it out
   always_comb begin
      idx  = int'(row) * n + int'(col);
      elem = '0;
      if ((int'(row) < n) && (int'(col) < n)) begin
         elem = vec[idx*EW +: EW];
      end
   end

endmodule

// File: rtl/sysarray_result_drain.sv
// Result drain for the systolic array: snapshots the n x n result matrix on the
// rising match of flg against DONE_FLG and streams it out row-major over
// valid/ready. Optional feature: define SYSARRAY_DRAIN_PARITY_EN to add the
// registered even-parity output out_parity.
module sysarray_result_drain
   import sysarray_pkg::*;
#(
   parameter int N        = SA_N,
   parameter int n        = SA_DIM,
   parameter int DONE_FLG = 3*n-1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              flg,
   input  logic [(N+1)*n*n-1:0]    c_flat,
   output logic [N:0]              out_data,
   output logic [idx_w(n)-1:0]     out_row,
   output logic [idx_w(n)-1:0]     out_col,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    busy,
   output logic                    ovf
`ifdef SYSARRAY_DRAIN_PARITY_EN
   ,output logic                   out_parity
`endif
);

   localparam int            EW      = N+1;
   localparam int            IW      = idx_w(n);
   localparam int            VW      = EW*n*n;
   localparam logic [IW-1:0] IDX_MAX = IW'(n-1);
   localparam logic [6:0]    DONE    = 7'(DONE_FLG);

   state_t        state, state_nxt;
   logic [6:0]    flg_prev;
   logic          trig;
   logic          cap;
   logic          xfer;
   logic          last;

   logic [VW-1:0] snap_p0;
   logic [IW-1:0] row_p0, col_p0;
   logic [IW-1:0] row_nxt, col_nxt;
   logic [EW-1:0] data_p0;
   logic [EW-1:0] elem_nxt;
`ifdef SYSARRAY_DRAIN_PARITY_EN
   logic          par_p0;
`endif

   // Rising match only: a flg parked at DONE_FLG must not fire again
   assign trig = (flg == DONE) && (flg_prev != DONE);

   // Everything the sink sees is decoded from registered state, never from out_ready
   assign out_valid = (state == STREAM);
   assign busy      = (state == STREAM);
   assign last      = out_valid && (row_p0 == IDX_MAX) && (col_p0 == IDX_MAX);
   assign out_last  = last;
   assign out_data  = data_p0;
   assign out_row   = row_p0;
   assign out_col   = col_p0;
`ifdef SYSARRAY_DRAIN_PARITY_EN
   assign out_parity = par_p0;
`endif

   // Column-first successor of the current index
   always_comb begin
      row_nxt = row_p0;
      col_nxt = col_p0 + 1'b1;
      if (col_p0 == IDX_MAX) begin
         col_nxt = '0;
         row_nxt = row_p0 + 1'b1;
      end
   end

   // Element that will be presented after the current one is accepted
   sysarray_elem_sel #(
      .N (N),
      .n (n)
   ) u_sel_nxt (
      .vec  (snap_p0),
      .row  (row_nxt),
      .col  (col_nxt),
      .elem (elem_nxt)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state plus capture/transfer strobes
   always_comb begin
      state_nxt = state;
      cap       = 1'b0;
      xfer      = 1'b0;
      case (state)
         IDLE: begin
            if (trig) begin
               cap       = 1'b1;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (out_ready) begin
               xfer = 1'b1;
               if (last) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Trigger edge history and sticky overflow (any trigger seen outside IDLE)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flg_prev <= '0;
         ovf      <= 1'b0;
      end else begin
         flg_prev <= flg;
         if (trig && (state == STREAM)) begin
            ovf <= 1'b1;
         end
      end
   end

   // ---- p0: snapshot, index and presented element ----
   // Snapshot on trigger; on each accepted element load its successor from the snapshot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_p0 <= '0;
         row_p0  <= '0;
         col_p0  <= '0;
         data_p0 <= '0;
      end else if (cap) begin
         snap_p0 <= c_flat;
         row_p0  <= '0;
         col_p0  <= '0;
         data_p0 <= c_flat[EW-1:0];
      end else if (xfer) begin
         if (last) begin
            row_p0  <= '0;
            col_p0  <= '0;
            data_p0 <= '0;
         end else begin
            row_p0  <= row_nxt;
            col_p0  <= col_nxt;
            data_p0 <= elem_nxt;
         end
      end
   end

`ifdef SYSARRAY_DRAIN_PARITY_EN
   // Parity tracks data_p0 load-for-load so it holds under backpressure with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_p0 <= 1'b0;
      end else if (cap) begin
         par_p0 <= ^c_flat[EW-1:0];
      end else if (xfer) begin
         par_p0 <= last ? 1'b0 : ^elem_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_sysarray_result_drain.sv
// Directed bench for sysarray_result_drain with n=2, N=31, DONE_FLG=5.
module tb_sysarray_result_drain;

   logic         clk;
   logic         rst_n;
   logic [6:0]   flg;
   logic [127:0] c_flat;
   logic [31:0]  out_data;
   logic [0:0]   out_row;
   logic [0:0]   out_col;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic         busy;
   logic         ovf;
`ifdef SYSARRAY_DRAIN_PARITY_EN
   logic         out_parity;
`endif

   int checks   = 0;
   int failures = 0;

   localparam logic [127:0] BASE = {32'd22, 32'd15, 32'd10, 32'd7};
   localparam logic [127:0] ALT  = {32'd4, 32'd3, 32'd2, 32'd1};

   sysarray_result_drain #(
      .N        (31),
      .n        (2),
      .DONE_FLG (5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flg        (flg),
      .c_flat     (c_flat),
      .out_data   (out_data),
      .out_row    (out_row),
      .out_col    (out_col),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .ovf        (ovf)
`ifdef SYSARRAY_DRAIN_PARITY_EN
      ,.out_parity (out_parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Check the element presented this cycle, then advance one cycle
   task automatic expect_elem(input logic [31:0] d, input logic r, input logic c,
                              input logic l, input logic p);
      chk("valid", 64'(out_valid), 64'd1);
      chk("busy",  64'(busy),      64'd1);
      chk("data",  64'(out_data),  64'(d));
      chk("row",   64'(out_row),   64'(r));
      chk("col",   64'(out_col),   64'(c));
      chk("last",  64'(out_last),  64'(l));
`ifdef SYSARRAY_DRAIN_PARITY_EN
      chk("parity", 64'(out_parity), 64'(p));
`endif
      @(negedge clk);
   endtask

   task automatic expect_idle(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_busy"},  64'(busy),      64'd0);
      chk({tag, "_last"},  64'(out_last),  64'd0);
   endtask

   // Step flg 0..5; returns at the negedge after the trigger edge
   task automatic step_to_done();
      for (int f = 0; f <= 5; f++) begin
         flg = 7'(f);
         @(negedge clk);
      end
   endtask

   task automatic full_stream();
      expect_elem(32'd7,  1'b0, 1'b0, 1'b0, 1'b1);
      expect_elem(32'd10, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_elem(32'd15, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_elem(32'd22, 1'b1, 1'b1, 1'b1, 1'b1);
   endtask

   initial begin
      rst_n     = 1'b0;
      flg       = '0;
      c_flat    = BASE;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state
      expect_idle("rst");
      chk("rst_ovf",  64'(ovf),      64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_row",  64'(out_row),  64'd0);
      chk("rst_col",  64'(out_col),  64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      expect_idle("pre");

      // Basic drain, then flg held at DONE must not retrigger
      step_to_done();
      full_stream();
      expect_idle("basic_end");
      for (int i = 0; i < 8; i++) begin
         chk("hold_valid", 64'(out_valid), 64'd0);
         @(negedge clk);
      end
      chk("hold_ovf", 64'(ovf), 64'd0);

      // Backpressure on element 10
      step_to_done();
      expect_elem(32'd7, 1'b0, 1'b0, 1'b0, 1'b1);
      out_ready = 1'b0;
      repeat (3) expect_elem(32'd10, 1'b0, 1'b1, 1'b0, 1'b0);
      out_ready = 1'b1;
      expect_elem(32'd10, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_elem(32'd15, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_elem(32'd22, 1'b1, 1'b1, 1'b1, 1'b1);
      expect_idle("bp_end");

      // Snapshot isolation: live inputs change right after capture
      step_to_done();
      c_flat = {128{1'b1}};
      full_stream();
      expect_idle("iso_end");
      c_flat = BASE;

      // Retrigger during streaming is ignored and flagged
      step_to_done();
      expect_elem(32'd7, 1'b0, 1'b0, 1'b0, 1'b1);
      flg    = 7'd0;
      c_flat = ALT;
      expect_elem(32'd10, 1'b0, 1'b1, 1'b0, 1'b0);
      flg = 7'd5;
      expect_elem(32'd15, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("retrig_ovf", 64'(ovf), 64'd1);
      expect_elem(32'd22, 1'b1, 1'b1, 1'b1, 1'b1);
      expect_idle("retrig_end");
      for (int i = 0; i < 4; i++) begin
         chk("retrig_quiet", 64'(out_valid), 64'd0);
         @(negedge clk);
      end
      chk("retrig_ovf_sticky", 64'(ovf), 64'd1);
      c_flat = BASE;

      // Asynchronous reset after two transfers
      step_to_done();
      expect_elem(32'd7,  1'b0, 1'b0, 1'b0, 1'b1);
      expect_elem(32'd10, 1'b0, 1'b1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      expect_idle("arst");
      chk("arst_ovf",  64'(ovf),      64'd0);
      chk("arst_data", 64'(out_data), 64'd0);
      chk("arst_row",  64'(out_row),  64'd0);
      chk("arst_col",  64'(out_col),  64'd0);
      @(negedge clk);
      flg   = 7'd0;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_quiet", 64'(out_valid), 64'd0);
      end
      step_to_done();
      full_stream();
      expect_idle("post_rst_end");

      // Trigger on the same edge as the final transfer is lost but flagged
      flg = 7'd0;
      @(negedge clk);
      step_to_done();
      expect_elem(32'd7, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_elem(32'd10, 1'b0, 1'b1, 1'b0, 1'b0);
      flg = 7'd0;
      expect_elem(32'd15, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("final_ovf_clear", 64'(ovf), 64'd0);
      flg = 7'd5;
      expect_elem(32'd22, 1'b1, 1'b1, 1'b1, 1'b1);
      expect_idle("final_end");
      chk("final_ovf", 64'(ovf), 64'd1);
      for (int i = 0; i < 3; i++) begin
         chk("final_lost", 64'(out_valid), 64'd0);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
